// File: rtl/debounce_pkg.sv
// Shared types and width helpers for the debounce bank and its per-channel slices.
package debounce_pkg;

  typedef struct packed {
    logic rise;
    logic fall;
  } edge_t;

  // Stable counter must hold values up to STABLE_TICKS.
  function automatic int cnt_w(input int stable_ticks);
    return (stable_ticks < 1) ? 1 : $clog2(stable_ticks + 1);
  endfunction

  // Prescaler counts 0..PRESCALE-1.
  function automatic int pre_w(input int prescale);
    return (prescale < 2) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced bit: synchroniser chain, stable-tick counter, level register
// and registered rise/fall pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   SYNC_STAGES  = 2,
  parameter int   STABLE_TICKS = 16,
  parameter logic INIT         = 1'b0
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  tick,
  input  logic  i,
  output logic  o,
  output edge_t pulse
);

  localparam int             CW   = cnt_w(STABLE_TICKS);
  localparam logic [CW-1:0]  LAST = CW'(STABLE_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic                   level_reg, level_next;
  edge_t                  pulse_reg, pulse_next;
  logic                   s;

  assign s = sync_reg[SYNC_STAGES-1];

  // Any agreeing tick restarts the count, so only an unbroken run flips the level.
  always_comb begin
    cnt_next   = cnt_reg;
    level_next = level_reg;
    pulse_next = '0;
    if (tick) begin
      if (s == level_reg) begin
        cnt_next = '0;
      end else if (cnt_reg == LAST) begin
        cnt_next        = '0;
        level_next      = s;
        pulse_next.rise = s;
        pulse_next.fall = ~s;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg  <= {SYNC_STAGES{INIT}};
      cnt_reg   <= '0;
      level_reg <= INIT;
      pulse_reg <= '0;
    end else begin
      sync_reg  <= {sync_reg[SYNC_STAGES-2:0], i};
      cnt_reg   <= cnt_next;
      level_reg <= level_next;
      pulse_reg <= pulse_next;
    end
  end

  assign o     = level_reg;
  assign pulse = pulse_reg;

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel debouncer with a shared sample prescaler; optional sticky
// edge flags and IRQ when DEBOUNCE_BANK_IRQ_EN is defined.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int                  CHANNELS     = 8,
  parameter int                  SYNC_STAGES  = 2,
  parameter int                  PRESCALE     = 5000,
  parameter int                  STABLE_TICKS = 16,
  parameter logic [CHANNELS-1:0] INIT         = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] i,
`ifdef DEBOUNCE_BANK_IRQ_EN
  input  logic [CHANNELS-1:0] i_clear,
  output logic [CHANNELS-1:0] o_pending,
  output logic                o_irq,
`endif
  output logic [CHANNELS-1:0] o,
  output logic [CHANNELS-1:0] o_rise,
  output logic [CHANNELS-1:0] o_fall
);

  if (CHANNELS < 1) begin : g_bad_channels
    $error("debounce_bank: CHANNELS must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("debounce_bank: SYNC_STAGES must be >= 2");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("debounce_bank: PRESCALE must be >= 1");
  end
  if (STABLE_TICKS < 1) begin : g_bad_stable
    $error("debounce_bank: STABLE_TICKS must be >= 1");
  end

  logic tick;

  // Free-running prescaler; never re-phased by input activity.
  if (PRESCALE == 1) begin : g_every_cycle
    assign tick = 1'b1;
  end else begin : g_prescale
    localparam int            PW       = pre_w(PRESCALE);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    logic [PW-1:0] pre_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        pre_reg <= '0;
      end else if (pre_reg == PRE_LAST) begin
        pre_reg <= '0;
      end else begin
        pre_reg <= pre_reg + 1'b1;
      end
    end

    assign tick = (pre_reg == PRE_LAST);
  end

  genvar gi;
  for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
    edge_t pulse;

    debounce_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_TICKS (STABLE_TICKS),
      .INIT         (INIT[gi])
    ) u_channel (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .i     (i[gi]),
      .o     (o[gi]),
      .pulse (pulse)
    );

    assign o_rise[gi] = pulse.rise;
    assign o_fall[gi] = pulse.fall;
  end

`ifdef DEBOUNCE_BANK_IRQ_EN
  logic [CHANNELS-1:0] pending_reg;

  // A new edge outranks a clear arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= (pending_reg & ~i_clear) | o_rise | o_fall;
    end
  end

  assign o_pending = pending_reg;
  assign o_irq     = |pending_reg;
`endif

endmodule
